// File: rtl/cube_layer_scanner.sv
`timescale 1ns/1ps
// cube_layer_scanner
// Scan controller for a 6x6x6 LED cube. Frame bytes land in a back buffer.
// The back buffer is copied to the front buffer only at a frame boundary.
// The front buffer is shown one layer at a time, and every layer is preceded
// by an all-off blanking gap so no layer ghosts into the next.
module cube_layer_scanner #(
  parameter int LAYER_CYCLES = 8000,
  parameter int BLANK_CYCLES = 50
) (
  input  logic        clk_clk,
  input  logic        reset_reset_n,
  input  logic        enable,
  input  logic [7:0]  s_data,
  input  logic        s_sof,
  input  logic        s_valid,
  output logic        s_ready,
  output logic [35:0] col,
  output logic [5:0]  layer,
  output logic        frame_done,
  output logic        sof_err
);

  localparam int CMAX = (LAYER_CYCLES > BLANK_CYCLES) ? LAYER_CYCLES : BLANK_CYCLES;
  localparam int CW   = (CMAX > 1) ? $clog2(CMAX) : 1;

  localparam logic [CW-1:0] LAST_ON    = CW'(LAYER_CYCLES - 1);
  localparam logic [CW-1:0] LAST_BLANK = CW'(BLANK_CYCLES - 1);
  localparam logic [CW-1:0] CNT_ONE    = CW'(1);
  localparam logic [4:0]    LAST_BYTE  = 5'd26;
  localparam logic [2:0]    LAST_LAYER = 3'd5;

  typedef enum logic {ST_BLANK, ST_ON} scan_state_t;

  scan_state_t      state, state_n;
  logic [CW-1:0]    ccnt, ccnt_n;
  logic [2:0]       lidx, lidx_n;
  logic             frame_end;
  logic             boundary;

  // Byte k of the back buffer holds frame bits 8k+7..8k; layer l of the
  // front buffer holds frame bits 36l+35..36l. Both flatten to the same
  // 216-bit ordering, so a plain copy performs the swap.
  logic [26:0][7:0] back_buf;
  logic [5:0][35:0] front_buf;
  logic [4:0]       wcnt;
  logic             swap_pending;
  logic             accept;

  // s_ready is the stored flag; a pending swap is simply "not ready".
  assign swap_pending = ~s_ready;
  assign accept       = s_valid & s_ready;
  // A disabled scanner shows nothing, so every disabled cycle is a boundary.
  assign boundary     = ~enable | frame_end;

  // Scan next-state: blank/on phase sequencing and layer advance.
  always_comb begin
    // NOTE: every output of this block gets a default first, so no path
    // leaves a value unassigned and no latch is inferred.
    state_n   = state;
    ccnt_n    = ccnt + CNT_ONE;
    lidx_n    = lidx;
    frame_end = 1'b0;
    if (!enable) begin
      state_n = ST_BLANK;
      ccnt_n  = '0;
      lidx_n  = '0;
    end else begin
      unique case (state)
        ST_BLANK: begin
          if (ccnt == LAST_BLANK) begin
            state_n = ST_ON;
            ccnt_n  = '0;
          end
        end
        ST_ON: begin
          if (ccnt == LAST_ON) begin
            state_n   = ST_BLANK;
            ccnt_n    = '0;
            frame_end = (lidx == LAST_LAYER);
            lidx_n    = frame_end ? 3'd0 : lidx + 3'd1;
          end
        end
        default: ;
      endcase
    end
  end

  // Scan state register; col/layer are registered from the next state so
  // they line up with the phase they belong to and switch together.
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      state      <= ST_BLANK;
      ccnt       <= '0;
      lidx       <= '0;
      col        <= '0;
      layer      <= '0;
      frame_done <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every
      // register samples pre-edge values regardless of statement order.
      state      <= state_n;
      ccnt       <= ccnt_n;
      lidx       <= lidx_n;
      frame_done <= frame_end;
      if (state_n == ST_ON) begin
        col   <= front_buf[lidx_n];
        layer <= 6'b000001 << lidx_n;
      end else begin
        col   <= '0;
        layer <= '0;
      end
    end
  end

  // Write side: byte capture into the back buffer and the boundary swap.
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      // NOTE: both buffers are flop arrays that must come up dark, so they
      // are cleared by reset rather than left as uninitialised storage.
      back_buf  <= '0;
      front_buf <= '0;
      wcnt      <= '0;
      s_ready   <= 1'b1;
      sof_err   <= 1'b0;
    end else begin
      sof_err <= 1'b0;
      if (accept) begin
        if (s_sof) begin
          // A start-of-frame always restarts the frame, even on byte 26.
          back_buf[0] <= s_data;
          wcnt        <= 5'd1;
          sof_err     <= (wcnt != 5'd0);
        end else begin
          back_buf[wcnt] <= s_data;
          if (wcnt == LAST_BYTE) begin
            wcnt    <= '0;
            s_ready <= 1'b0;
          end else begin
            wcnt <= wcnt + 5'd1;
          end
        end
      end else if (swap_pending && boundary) begin
        // Only a flag set before this edge swaps, so a frame completing on a
        // boundary cycle waits for the next boundary.
        front_buf <= back_buf;
        s_ready   <= 1'b1;
      end
    end
  end

endmodule

// File: doc/cube_layer_scanner.md
# cube_layer_scanner

Multiplexed scan controller for the 6x6x6 LED cube. It accepts frame data as a byte stream from the UART-fed control logic into a back buffer. It swaps that buffer into a front buffer only at frame boundaries, then drives one layer at a time onto the 36 column lines and 6 layer lines, inserting blanking gaps to prevent ghosting.

## Interface
Parameters:
- LAYER_CYCLES, 8000: cycles each layer is lit (≥1)
- BLANK_CYCLES, 50: all-off cycles before each layer (≥1)

Ports:
- clk_clk  in  1  system clock
- reset_reset_n  in  1  reset; one clock; reset is asynchronous and active-low
- enable  in  1  scan enable (SW-driven)
- s_data  in  8  frame byte
- s_sof  in  1  byte carries frame start (qualifies s_data as byte 0)
- s_valid  in  1  byte valid
- s_ready  out  1  byte accepted when s_valid & s_ready
- col  out  36  column drive, active-high
- layer  out  6  layer select, one-hot, active-high
- frame_done  out  1  one-cycle pulse at end of each scanned frame
- sof_err  out  1  one-cycle pulse when a partial frame is discarded

## Operation
- Frame = 216 bits = 27 bytes. Byte k bit b maps to frame bit 8k+b. Frame bit index = layer*36 + col.
- Write side:
  - Byte counter wcnt 0..26.
  - Accepted byte with s_sof=1 is written as byte 0 and sets wcnt=1. If wcnt≠0 at that moment, pulse sof_err; the old partial bytes are abandoned and not cleared.
  - Accepted byte with s_sof=0 writes byte wcnt and increments wcnt.
  - Acceptance of byte 26 clears wcnt, sets swap_pending and drops s_ready.
- s_ready = !swap_pending.
- Swap: when swap_pending is set and a frame boundary occurs, front buffer <= back buffer and swap_pending clears. A frame boundary is the last ON cycle of layer 5, or any cycle while enable=0.
- Scan FSM with states BLANK and ON, cycle counter ccnt and layer index lidx 0..5:
  - BLANK: col=0, layer=0. Stay for BLANK_CYCLES, then go to ON with ccnt=0.
  - ON: col=front[lidx*36 +: 36], layer=1<<lidx. Stay for LAYER_CYCLES, then go to BLANK. lidx advances, wrapping 5→0.
  - frame_done pulses in the cycle after the last ON cycle of layer 5.
- enable=0: FSM held in BLANK with lidx=0, ccnt=0, and col/layer=0. The write side and swaps stay active. On enable rising, the scan starts with a full BLANK period for layer 0.
- Reset values: col=0, layer=0, frame_done=0, sof_err=0, s_ready=1. Front and back buffers all 0, wcnt=0, swap_pending=0, state BLANK, lidx=0, ccnt=0.
- Reset asserted mid-frame or mid-write aborts everything immediately to the reset values.

## Timing
- All outputs are registered.
- col and layer change in the same cycle. col is never nonzero while layer=0, and vice versa.
- Layer period = BLANK_CYCLES + LAYER_CYCLES cycles. Frame period = 6 × layer period.
- Swap latency: the new frame first appears on col at the first ON cycle of layer 0 after the swap.
- s_ready rises the cycle after the swap. A byte presented in that cycle is accepted.
- The byte that completes a frame and a frame-boundary cycle can coincide. In that case the swap happens at the next boundary, never in the same cycle. While enable=0, the next boundary is the following cycle.
- Byte 26 accepted with s_sof=1 is treated as byte 0 of a new frame (sof rule wins).

## Test plan
- Reset: hold reset_reset_n low mid-scan -> col=0, layer=0, s_ready=1 asynchronously. After release with LAYER_CYCLES=4 and BLANK_CYCLES=2, the first ON cycle is at cycle 3 with layer=6'b000001.
- Write 27 bytes (sof on the first) with byte 0 = 8'h01 and others 0 -> s_ready drops after byte 26. After the next frame_done, layer 0 ON shows col=36'h1. s_ready returns high 1 cycle after the swap.
- Pattern with all frame bits for layer 3 set -> col=36'hFFFFFFFFF only while layer=6'b001000, and col=0 in every BLANK cycle.
- Send 10 bytes, then a byte with s_sof=1 -> sof_err pulses once. 26 further bytes complete the frame. The displayed frame contains no bytes from the aborted partial frame.
- enable=0 with a frame pending -> swap occurs the next cycle and outputs stay 0. Raise enable -> 2 BLANK cycles, then layer 0 with the new data. frame_done period = 36 cycles.
- Back-to-back frames with s_valid held high -> exactly one swap per scanned frame. s_ready stays low from byte 26 until the boundary, and no bytes are lost or duplicated.
